playback_fifo: RTL and testbench
================================

PLAYBACK_FIFO -- requirements
Module: playback_fifo

Interface
REQ-001: Parameter DEPTH, default 4, number of stored playback words; SHALL be a power of two, 2..16.
REQ-002: Parameter WIDTH, default 32, word width; bits [2i+1:2i] hold playback slot i as {enable,out}, i = 0..15.
REQ-003: clk  in  1  clock; all logic SHALL be on its rising edge.
REQ-004: resetN  in  1  reset, synchronous, active-low.
REQ-005: flush  in  1  synchronous clear of contents and status.
REQ-006: wrValid  in  1  producer offers wrData this cycle.
REQ-007: wrData  in  WIDTH  playback word from memory fetch.
REQ-008: wrReady  out  1  FIFO accepts a word this cycle.
REQ-009: advFIFO  in  1  consumer advance request, level signal held for one or more cycles.
REQ-010: headData  out  WIDTH  oldest stored word, presented to the playback unit.
REQ-011: headValid  out  1  headData holds a stored word.
REQ-012: count  out  $clog2(DEPTH+1)  words stored.
REQ-013: underflow  out  1  sticky flag: advance attempted while empty.
REQ-014: underflowCount  out  16  underflow events (see Configuration).
REQ-015: highWater  out  $clog2(DEPTH+1)  peak count since reset/flush (see Configuration).

Function
REQ-016: A push SHALL occur on a clock edge where wrValid=1 and wrReady=1; wrReady SHALL equal (count != DEPTH), with no dependence on advFIFO.
REQ-017: A pushed word SHALL appear on headData one cycle after the push edge if the FIFO was empty.
REQ-018: The block SHALL register advFIFO once (advPrev); an advance event SHALL be advFIFO=1 and advPrev=0, so each held request pops exactly one word.
REQ-019: An advance event with count>0 SHALL pop the head; the next word (or empty) SHALL be visible the following cycle.
REQ-020: An advance event with count=0 SHALL set underflow, leave pointers and count unchanged.
REQ-021: Simultaneous push and pop with 0<count<DEPTH SHALL leave count unchanged and preserve order.
REQ-022: Push while empty and advance event in the same cycle SHALL push only; the advance SHALL count as underflow.
REQ-023: Read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor go below 0.
REQ-024: headValid SHALL equal (count != 0); headData SHALL be all zeros (all slots disabled) when count=0.
REQ-025: flush=1 SHALL, at that edge, zero pointers, count, underflow, underflowCount, highWater; push and pop in that cycle SHALL be ignored; advPrev SHALL still load advFIFO.
REQ-026: Storage contents SHALL not require reset; only control state is reset.

Reset
REQ-027: With resetN=0 at a clock edge: pointers, count, advPrev, underflow, underflowCount, highWater SHALL be 0; wrReady=1, headValid=0, headData=0 during the following cycle.
REQ-028: resetN SHALL take priority over flush, push and pop; reset mid-stream SHALL discard all stored words.

Configuration
REQ-029: Macro PLAYBACK_FIFO_STATS_EN defined: underflowCount SHALL increment (saturating at 16'hFFFF) on each underflow event; highWater SHALL track max count.
REQ-030: Macro undefined: underflowCount and highWater ports SHALL exist and be driven constant 0; all other behaviour identical.

Verification
REQ-031: Reset, push 32'hA5A5_0001 -> next cycle headValid=1, headData=32'hA5A5_0001, count=1.
REQ-032: Push 4 words with DEPTH=4 -> wrReady=0, count=4; fifth wrValid not accepted; hold advFIFO=1 for 5 cycles -> exactly one pop, count=3, wrReady=1.
REQ-033: Pulse advFIFO 3 times on 3 stored words W0..W2 -> headData W1, W2, then 0 with headValid=0; order preserved.
REQ-034: Advance while empty twice -> underflow=1; with STATS_EN underflowCount=2, without it 0; count stays 0.
REQ-035: count=2, push and advance same cycle -> count=2, new word third in order; then flush -> count=0, underflow=0, highWater=0.
REQ-036: Fill 6 pushes/6 pops interleaved across pointer wrap -> data order intact; resetN=0 mid-sequence -> headValid=0, wrReady=1 next cycle.

Source files
------------

// File: rtl/playback_fifo.sv
// playback_fifo: small FIFO of playback words between the memory fetch and the
// playback unit. Each word packs 2-bit slots {enable,out}; an empty FIFO shows an
// all-zero head word, so every slot reads as disabled.
//
// Ports:
//   clk            rising-edge clock
//   resetN         synchronous active-low reset of control state
//   flush          synchronous clear of contents and status
//   wrValid/wrData producer offer; push when wrValid && wrReady
//   wrReady        space available (count != DEPTH)
//   advFIFO        consumer advance level; its rising edge pops one word
//   headData       oldest stored word, zero when empty
//   headValid      headData holds a stored word
//   count          words stored
//   underflow      sticky: advance seen while empty
//   underflowCount saturating underflow event count (stats build only)
//   highWater      peak count since reset/flush (stats build only)
//
// Define PLAYBACK_FIFO_STATS_EN to enable underflowCount/highWater; without it
// both ports are tied to zero.
module playback_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           resetN,
    input  logic                           flush,
    input  logic                           wrValid,
    input  logic [WIDTH-1:0]               wrData,
    output logic                           wrReady,
    input  logic                           advFIFO,
    output logic [WIDTH-1:0]               headData,
    output logic                           headValid,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           underflow,
    output logic [15:0]                    underflowCount,
    output logic [$clog2(DEPTH+1)-1:0]     highWater
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : gDepthCheck
        $error("playback_fifo: DEPTH must be a power of two in 2..16");
    end

    // Storage is deliberately left unreset; count gates every read of it.
    logic [WIDTH-1:0] memQ [DEPTH];

    logic [PtrW-1:0] wrPtrQ, wrPtrD;
    logic [PtrW-1:0] rdPtrQ, rdPtrD;
    logic [CntW-1:0] countQ, countD;
    logic            advPrevQ;
    logic            underflowQ, underflowD;

    logic advEvent;
    logic doPush;
    logic doPop;
    logic uflEvent;

    // An advance is the rising edge of the held level, so one request pops once.
    always_comb begin
        advEvent = advFIFO & ~advPrevQ;
        doPush   = wrValid & wrReady & ~flush;
        doPop    = advEvent & (countQ != '0) & ~flush;
        // With the FIFO empty the advance cannot see a same-cycle push.
        uflEvent = advEvent & (countQ == '0) & ~flush;
    end

    always_comb begin
        wrPtrD     = wrPtrQ;
        rdPtrD     = rdPtrQ;
        countD     = countQ;
        underflowD = underflowQ;
        if (flush) begin
            wrPtrD     = '0;
            rdPtrD     = '0;
            countD     = '0;
            underflowD = 1'b0;
        end else begin
            if (doPush) begin
                wrPtrD = wrPtrQ + PtrW'(1);
            end
            if (doPop) begin
                rdPtrD = rdPtrQ + PtrW'(1);
            end
            countD = countQ + CntW'(doPush) - CntW'(doPop);
            if (uflEvent) begin
                underflowD = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            wrPtrQ     <= '0;
            rdPtrQ     <= '0;
            countQ     <= '0;
            advPrevQ   <= 1'b0;
            underflowQ <= 1'b0;
        end else begin
            wrPtrQ     <= wrPtrD;
            rdPtrQ     <= rdPtrD;
            countQ     <= countD;
            advPrevQ   <= advFIFO;
            underflowQ <= underflowD;
        end
    end

    always_ff @(posedge clk) begin
        if (resetN && doPush) begin
            memQ[wrPtrQ] <= wrData;
        end
    end

`ifdef PLAYBACK_FIFO_STATS_EN
    logic [15:0]     uflCntQ, uflCntD;
    logic [CntW-1:0] highWaterQ, highWaterD;

    always_comb begin
        uflCntD    = uflCntQ;
        highWaterD = highWaterQ;
        if (flush) begin
            uflCntD    = '0;
            highWaterD = '0;
        end else begin
            if (uflEvent && uflCntQ != 16'hFFFF) begin
                uflCntD = uflCntQ + 16'd1;
            end
            // Track against the post-edge count so the peak includes this cycle.
            if (countD > highWaterQ) begin
                highWaterD = countD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            uflCntQ    <= '0;
            highWaterQ <= '0;
        end else begin
            uflCntQ    <= uflCntD;
            highWaterQ <= highWaterD;
        end
    end

    assign underflowCount = uflCntQ;
    assign highWater      = highWaterQ;
`else
    assign underflowCount = 16'd0;
    assign highWater      = '0;
`endif

    assign wrReady   = (countQ != FullCnt);
    assign headValid = (countQ != '0);
    assign headData  = (countQ != '0) ? memQ[rdPtrQ] : '0;
    assign count     = countQ;
    assign underflow = underflowQ;

endmodule

// File: tb/tb_playback_fifo.sv
// Self-checking bench for playback_fifo: a queue-based model of the FIFO is
// compared against every output on each falling edge, and directed sequences
// add literal expectations that pin the model itself.
module tb_playback_fifo;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             resetN;
    logic             flush;
    logic             wrValid;
    logic [WIDTH-1:0] wrData;
    logic             wrReady;
    logic             advFIFO;
    logic [WIDTH-1:0] headData;
    logic             headValid;
    logic [CW-1:0]    count;
    logic             underflow;
    logic [15:0]      underflowCount;
    logic [CW-1:0]    highWater;

    playback_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk            (clk),
        .resetN         (resetN),
        .flush          (flush),
        .wrValid        (wrValid),
        .wrData         (wrData),
        .wrReady        (wrReady),
        .advFIFO        (advFIFO),
        .headData       (headData),
        .headValid      (headValid),
        .count          (count),
        .underflow      (underflow),
        .underflowCount (underflowCount),
        .highWater      (highWater)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, plus the status the outputs must show.
    logic [WIDTH-1:0] mq[$];
    bit               mAdvPrev = 1'b0;
    bit               mUfl     = 1'b0;
    int               mUflCnt  = 0;
    int               mHigh    = 0;
    bit               checkEn  = 1'b0;

    always @(posedge clk) begin
        if (!resetN) begin
            mq.delete();
            mAdvPrev = 1'b0;
            mUfl     = 1'b0;
            mUflCnt  = 0;
            mHigh    = 0;
            checkEn  = 1'b1;
        end else if (flush) begin
            mq.delete();
            mUfl     = 1'b0;
            mUflCnt  = 0;
            mHigh    = 0;
            mAdvPrev = advFIFO;
        end else begin
            bit adv;
            bit canPush;
            adv     = advFIFO && !mAdvPrev;
            canPush = (mq.size() != DEPTH);
            if (adv) begin
                if (mq.size() != 0) begin
                    void'(mq.pop_front());
                end else begin
                    mUfl = 1'b1;
                    if (mUflCnt != 16'hFFFF) mUflCnt++;
                end
            end
            if (wrValid && canPush) mq.push_back(wrData);
            mAdvPrev = advFIFO;
            if (mq.size() > mHigh) mHigh = mq.size();
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            logic [31:0] expHead;
            logic [31:0] expUc;
            logic [31:0] expHw;
            expHead = (mq.size() != 0) ? mq[0] : 32'h0;
`ifdef PLAYBACK_FIFO_STATS_EN
            expUc = 32'(mUflCnt);
            expHw = 32'(mHigh);
`else
            expUc = 32'h0;
            expHw = 32'h0;
`endif
            check("model.headValid", 32'(headValid), 32'(mq.size() != 0));
            check("model.headData", headData, expHead);
            check("model.count", 32'(count), 32'(mq.size()));
            check("model.wrReady", 32'(wrReady), 32'(mq.size() != DEPTH));
            check("model.underflow", 32'(underflow), 32'(mUfl));
            check("model.underflowCount", 32'(underflowCount), expUc);
            check("model.highWater", 32'(highWater), expHw);
        end
    end

    // Inputs only change 1 time unit after a falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic doReset();
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        wrValid = 1'b1;
        wrData  = d;
        tick();
        wrValid = 1'b0;
    endtask

    task automatic pulseAdv();
        advFIFO = 1'b1;
        tick();
        advFIFO = 1'b0;
        tick();
    endtask

    initial begin
        resetN  = 1'b0;
        flush   = 1'b0;
        wrValid = 1'b0;
        wrData  = '0;
        advFIFO = 1'b0;
        tick();
        tick();
        resetN = 1'b1;
        check("reset.headValid", 32'(headValid), 32'h0);
        check("reset.wrReady", 32'(wrReady), 32'h1);
        check("reset.headData", headData, 32'h0);
        check("reset.count", 32'(count), 32'h0);

        // First push is visible on the head the next cycle.
        push(32'hA5A5_0001);
        check("first.headValid", 32'(headValid), 32'h1);
        check("first.headData", headData, 32'hA5A5_0001);
        check("first.count", 32'(count), 32'h1);

        // Fill, refuse a fifth word, then a held advance pops only once.
        doReset();
        for (int i = 0; i < 4; i++) push(32'h1000_0000 + 32'(i));
        check("full.count", 32'(count), 32'h4);
        check("full.wrReady", 32'(wrReady), 32'h0);
        push(32'hDEAD_BEEF);
        check("full.fifthRejected", 32'(count), 32'h4);
        advFIFO = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        advFIFO = 1'b0;
        tick();
        check("held.count", 32'(count), 32'h3);
        check("held.wrReady", 32'(wrReady), 32'h1);
        check("held.headData", headData, 32'h1000_0001);

        // Three pulses drain the three remaining words in order.
        pulseAdv();
        check("drain.head1", headData, 32'h1000_0002);
        pulseAdv();
        check("drain.head2", headData, 32'h1000_0003);
        pulseAdv();
        check("drain.headEmpty", headData, 32'h0);
        check("drain.headValid", 32'(headValid), 32'h0);

        // Two advances while empty.
        pulseAdv();
        pulseAdv();
        check("ufl.flag", 32'(underflow), 32'h1);
`ifdef PLAYBACK_FIFO_STATS_EN
        check("ufl.count", 32'(underflowCount), 32'h2);
`else
        check("ufl.count", 32'(underflowCount), 32'h0);
`endif
        check("ufl.fifoCount", 32'(count), 32'h0);

        // Simultaneous push and pop at count=2, then flush.
        push(32'hC0DE_0000);
        push(32'hC0DE_0001);
        wrValid = 1'b1;
        wrData  = 32'hC0DE_0002;
        advFIFO = 1'b1;
        tick();
        wrValid = 1'b0;
        advFIFO = 1'b0;
        check("sim.count", 32'(count), 32'h2);
        check("sim.head", headData, 32'hC0DE_0001);
        tick();
        pulseAdv();
        check("sim.third", headData, 32'hC0DE_0002);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush.count", 32'(count), 32'h0);
        check("flush.underflow", 32'(underflow), 32'h0);
        check("flush.highWater", 32'(highWater), 32'h0);

        // Interleaved traffic across pointer wrap, then a mid-stream reset.
        doReset();
        push(32'h5EED_0000);
        push(32'h5EED_0001);
        for (int i = 2; i < 6; i++) begin
            wrValid = 1'b1;
            wrData  = 32'h5EED_0000 + 32'(i);
            advFIFO = 1'b1;
            tick();
            wrValid = 1'b0;
            advFIFO = 1'b0;
            check("wrap.head", headData, 32'h5EED_0000 + 32'(i - 1));
            tick();
        end
        pulseAdv();
        check("wrap.last", headData, 32'h5EED_0005);
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        check("midReset.headValid", 32'(headValid), 32'h0);
        check("midReset.wrReady", 32'(wrReady), 32'h1);

        // Random traffic checked every cycle by the model comparison.
        for (int i = 0; i < 3000; i++) begin
            wrValid = ($urandom_range(0, 99) < 55);
            wrData  = $urandom;
            advFIFO = ($urandom_range(0, 99) < 45);
            flush   = ($urandom_range(0, 99) == 0);
            resetN  = ($urandom_range(0, 199) != 0);
            tick();
        end
        resetN  = 1'b1;
        flush   = 1'b0;
        wrValid = 1'b0;
        advFIFO = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
